// File: rtl/sr_latch_ctrl_pkg.sv
// Shared types for the SR latch sequencer: FSM states, pending-op encoding,
// and the pulse/gap counter width helper.
package sr_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_SET  = 2'd1,
      OP_CLR  = 2'd2
   } op_e;

   function automatic int cnt_width(input int pulse_cyc, input int gap_cyc);
      int m;
      m = (pulse_cyc > gap_cyc) ? pulse_cyc : gap_cyc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sr_latch_ctrl_arb.sv
// Round-robin picker: first requester at or after ptr, wrapping; combinational, no backpressure.
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IW = $clog2(N_REQ);

   int   cand;
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = (int'(ptr) + k) % N_REQ;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Shares one SR latch among N_REQ requesters: round-robin, PULSE_CYC-wide s/r pulses, GAP_CYC guard, ack in last gap cycle.
// Requests never stall (last writer wins per requester); SR_LATCH_CTRL_SHADOW_EN skips ops matching the tracked latch state.
module sr_latch_ctrl #(
   parameter int N_REQ     = 4,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] set_req,
   input  logic [N_REQ-1:0] clr_req,
   output logic [N_REQ-1:0] ack,
   output logic [N_REQ-1:0] err,
   output logic             s,
   output logic             r,
   output logic             busy,
   output logic             q_shadow
);
   import sr_ctrl_pkg::*;

   localparam int IW = $clog2(N_REQ);
   localparam int CW = cnt_width(PULSE_CYC, GAP_CYC);

   op_e              pend [N_REQ];
   logic [N_REQ-1:0] pend_vld;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] gnt_q;
   logic [IW-1:0]    gnt_idx;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    ptr_nxt;
   op_e              gnt_op;
   state_e           state;
   logic [CW-1:0]    cnt;
   logic             grant;
   logic             skip;
   logic             done;

   always_comb begin
      pend_vld = '0;
      for (int i = 0; i < N_REQ; i++) begin
         pend_vld[i] = (pend[i] != OP_NONE);
      end
   end

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req (pend_vld),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   assign gnt_op  = pend[gnt_idx];
   assign grant   = (state == ST_IDLE) && (|pend_vld);
   assign done    = (state == ST_GAP) && (cnt == '0);
   assign ptr_nxt = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   // A fresh single request outranks the grant-clear, so it is served later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            pend[i] <= OP_NONE;
         end
      end else begin
         err <= set_req & clr_req;
         for (int i = 0; i < N_REQ; i++) begin
            if (set_req[i] && !clr_req[i]) begin
               pend[i] <= OP_SET;
            end else if (clr_req[i] && !set_req[i]) begin
               pend[i] <= OP_CLR;
            end else if (grant && gnt[i]) begin
               pend[i] <= OP_NONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         s      <= 1'b0;
         r      <= 1'b0;
         ack    <= '0;
         busy   <= 1'b0;
         gnt_q  <= '0;
         rr_ptr <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  rr_ptr <= ptr_nxt;
                  gnt_q  <= gnt;
                  if (skip) begin
                     ack <= gnt;
                  end else begin
                     state <= ST_PULSE;
                     cnt   <= CW'(PULSE_CYC - 1);
                     s     <= (gnt_op == OP_SET);
                     r     <= (gnt_op == OP_CLR);
                     busy  <= 1'b1;
                  end
               end
            end
            ST_PULSE: begin
               if (cnt == '0) begin
                  state <= ST_GAP;
                  cnt   <= CW'(GAP_CYC - 1);
                  s     <= 1'b0;
                  r     <= 1'b0;
                  if (GAP_CYC == 1) ack <= gnt_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (done) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) ack <= gnt_q;
               end
            end
            default: begin
               state <= ST_IDLE;
               s     <= 1'b0;
               r     <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SR_LATCH_CTRL_SHADOW_EN
   logic shadow_q;
   logic shadow_vld;
   logic cur_set;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q   <= 1'b0;
         shadow_vld <= 1'b0;
         cur_set    <= 1'b0;
      end else begin
         if (grant && !skip) cur_set <= (gnt_op == OP_SET);
         if (done) begin
            shadow_q   <= cur_set;
            shadow_vld <= 1'b1;
         end
      end
   end

   assign skip     = shadow_vld && ((gnt_op == OP_SET) == shadow_q);
   assign q_shadow = shadow_q;
`else
   assign skip     = 1'b0;
   assign q_shadow = 1'b0;
`endif

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Sequencer that shares one SR latch between N requesters. It captures per-requester set/clear requests, arbitrates round-robin, and drives the latch's `s`/`r` inputs with fixed-width pulses separated by a guard gap. It guarantees that `s` and `r` are never high together, so the latch is never driven into its forbidden state. It sits directly in front of the latch instance and returns a one-cycle acknowledge to each requester when its operation is complete.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `PULSE_CYC`, default 2: width of each `s` or `r` pulse in cycles; must be ≥ 1.
- `GAP_CYC`, default 1: cycles with both `s` and `r` low after each pulse; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `set_req`  in  N_REQ  single-cycle set request, one bit per requester.
- `clr_req`  in  N_REQ  single-cycle clear request, one bit per requester.
- `ack`  out  N_REQ  one-cycle completion pulse, one-hot.
- `err`  out  N_REQ  one-cycle pulse: `set_req[i]` and `clr_req[i]` arrived in the same cycle.
- `s`  out  1  latch set drive, registered.
- `r`  out  1  latch reset drive, registered.
- `busy`  out  1  high in PULSE and GAP.
- `q_shadow`  out  1  tracked latch state (see Configuration).

## Operation
- Per-requester pending register `pend[i]` holds an op: NONE, SET or CLR.
  - `set_req[i]` alone loads SET; `clr_req[i]` alone loads CLR.
  - A newer request overwrites an older pending op (last writer wins).
  - Both requests in the same cycle: `pend[i]` is unchanged and `err[i]` pulses in the next cycle.
- FSM states:
  - IDLE: if any `pend` is not NONE, select the first requester at or after pointer `rr_ptr`, wrapping mod N_REQ. Record the grant index and op, clear that `pend`, set `rr_ptr` to idx+1 mod N_REQ, go to PULSE. Otherwise stay in IDLE.
  - PULSE: drive `s` (for SET) or `r` (for CLR) for PULSE_CYC cycles, then go to GAP.
  - GAP: `s` and `r` both low for GAP_CYC cycles. `ack[grant]` is high in the last GAP cycle; the FSM then returns to IDLE.
- A request that arrives for the granted requester during PULSE or GAP is captured as a new pending op and is served in a later arbitration.
- Invariant: `s & r` is never 1.
- Cycle counter width is `$clog2(max(PULSE_CYC, GAP_CYC)+1)`. It reloads on every state entry and does not wrap.

## Timing
- Reset (asynchronous, effective immediately):
  - `s`, `r`, `ack`, `err`, `busy`, `q_shadow` = 0.
  - All `pend` = NONE; `rr_ptr` = 0; FSM = IDLE; shadow valid = 0.
- Reset during PULSE drops `s`/`r` without waiting for a clock edge. The aborted op is not acknowledged.
- Uncontended latency, with the request high in cycle 0:
  - cycle 1: `pend` set.
  - cycles 2 .. PULSE_CYC+1: `s`/`r` high.
  - cycles PULSE_CYC+2 .. PULSE_CYC+GAP_CYC+1: gap.
  - cycle PULSE_CYC+GAP_CYC+1: `ack` high.
  - The next grant can start pulsing in cycle PULSE_CYC+GAP_CYC+3.
- `busy` is high in exactly the cycles where the FSM is in PULSE or GAP.

## Configuration
- `SR_LATCH_CTRL_SHADOW_EN` defined:
  - A shadow register follows every completed op, with a valid bit that is cleared by reset.
  - When IDLE grants an op equal to the shadow value while valid = 1, no pulse is issued: `ack[i]` pulses in cycle 2 and the FSM stays in IDLE.
  - `q_shadow` outputs the shadow value.
- Macro undefined: every op is pulsed and `q_shadow` is tied to 0.

## Structure
- Shared package `sr_ctrl_pkg`:
  - state enum (IDLE/PULSE/GAP);
  - op enum (NONE/SET/CLR, 2 bits);
  - helper function computing the counter width.
- One sub-module, `rr_arbiter`:
  - parameterised by N_REQ;
  - request vector and pointer in, one-hot grant and index out;
  - purely combinational.

## Test plan
- Reset, then `set_req[0]` in cycle 0 with defaults → `s` high in cycles 2–3, gap in cycle 4, `ack[0]` in cycle 4, `r` stays 0.
- `set_req[1]` and `clr_req[3]` in the same cycle → SET for requester 1 first, then CLR for 3. Pulses separated by ≥ 1 gap cycle; `s & r` never high.
- `set_req[2]` and `clr_req[2]` together → `err[2]` pulses next cycle, no pulse, no `ack`.
- All four requesters pending continuously → grants in order 0, 1, 2, 3, 0. No requester is granted twice before all others are served.
- Assert `rst` midway through a PULSE → `s` drops immediately; no `ack`; after release, all `pend` empty and FSM in IDLE.
- With `SR_LATCH_CTRL_SHADOW_EN`: SET, then SET again → second `ack` arrives in cycle 2 with no `s` pulse, and `q_shadow` = 1. Without the macro, the same stimulus produces a second `s` pulse.
